// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman encoder: default widths, FSM states and
// the helper that sizes code-length fields.
package huffman_pkg;

  localparam int D_W_DEF = 4;
  localparam int C_W_DEF = 4;
  localparam int O_W_DEF = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Bits needed to hold a code length in the range 0..c_w.
  function automatic int len_w(input int c_w);
    return $clog2(c_w + 1);
  endfunction

endpackage

// File: rtl/huffman_bit_packer.sv
// Bit accumulator for the Huffman encoder: appends variable-length codes
// MSB-first and presents the oldest O_W bits as an MSB-aligned word.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int C_W = C_W_DEF,
  parameter int O_W = O_W_DEF,
  parameter int L_W = len_w(C_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           append,
  input  logic [C_W-1:0] code,
  input  logic [L_W-1:0] len,
  input  logic           pop,
  input  logic           drop,
  output logic [O_W-1:0] word,
  output logic           full,
  output logic           empty
);

  localparam int A_W   = O_W + C_W - 1;
  localparam int CNT_W = $clog2(A_W + 1);
  localparam logic [CNT_W-1:0] O_W_CNT = CNT_W'(O_W);

  logic [A_W-1:0]   acc;
  logic [A_W-1:0]   placed;
  logic [C_W-1:0]   masked;
  logic [CNT_W-1:0] cnt;

  // Pending bits sit MSB-aligned, so zero padding of a partial word is free.
  // Appends only happen with cnt < O_W, so cnt + len never exceeds A_W.
  always_comb begin
    masked = '0;
    for (int i = 0; i < C_W; i++) begin
      masked[i] = code[i] && (i < int'(len));
    end
    placed = (A_W'(masked) << (A_W - int'(len))) >> cnt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear || drop) begin
      acc <= '0;
      cnt <= '0;
    end else if (pop) begin
      acc <= acc << O_W;
      cnt <= cnt - O_W_CNT;
    end else if (append) begin
      acc <= acc | placed;
      cnt <= cnt + CNT_W'(len);
    end
  end

  assign word  = acc[A_W-1 -: O_W];
  assign full  = (cnt >= O_W_CNT);
  assign empty = (cnt == '0);

endmodule

// File: rtl/huffman_enc.sv
// Table-driven Huffman encoder: symbol lookup, RUN/FLUSH control and the
// input/output handshakes around a bit packer.
module huffman_enc
  import huffman_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int C_W = C_W_DEF,
  parameter int O_W = O_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [D_W-1:0]         d_conf,
  input  logic [C_W-1:0]         h_conf,
  input  logic [len_w(C_W)-1:0]  l_conf,
  input  logic                   en_conf,
  input  logic                   new_conf,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D_W-1:0]         in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_W-1:0]         out_data,
  output logic                   out_last,
  output logic                   flush_done,
  output logic                   err
);

  localparam int L_W   = len_w(C_W);
  localparam int DEPTH = 2 ** D_W;

  logic [C_W-1:0]   code_mem [DEPTH];
  logic [L_W-1:0]   len_mem  [DEPTH];
  logic [DEPTH-1:0] valid_bits;

  state_t state, state_next;
  logic   full, empty;
  logic   accept, hit, append, pop, drop;

  // Code storage is deliberately left out of reset; only valid bits are cleared.
  always_ff @(posedge clk) begin
    if (en_conf && !new_conf) begin
      code_mem[d_conf] <= h_conf;
      len_mem[d_conf]  <= l_conf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      valid_bits <= '0;
    end else if (en_conf) begin
      valid_bits[d_conf] <= (l_conf != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      err <= 1'b0;
    end else if (accept && !hit) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || new_conf) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:   if (flush) state_next = FLUSH;
      FLUSH: if (empty || (out_valid && out_ready && out_last)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // A partial word in FLUSH completes the flush on the same cycle it transfers.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        in_ready  = !full && !en_conf && !new_conf;
        out_valid = full;
      end
      FLUSH: begin
        if (full) begin
          out_valid = 1'b1;
        end else if (!empty) begin
          out_valid  = 1'b1;
          out_last   = 1'b1;
          flush_done = out_ready;
        end else begin
          flush_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign hit    = valid_bits[in_data];
  assign append = accept && hit;
  assign pop    = out_valid && out_ready && !out_last;
  assign drop   = out_valid && out_ready && out_last;

  huffman_bit_packer #(
    .C_W(C_W),
    .O_W(O_W),
    .L_W(L_W)
  ) u_packer (
    .clk   (clk),
    .rst   (rst),
    .clear (new_conf),
    .append(append),
    .code  (code_mem[in_data]),
    .len   (len_mem[in_data]),
    .pop   (pop),
    .drop  (drop),
    .word  (out_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_huffman_enc.sv
// Self-checking bench for huffman_enc: fixed vectors, directed corner cases
// and random traffic against a bit-queue reference model.
module tb_huffman_enc;

  localparam int D_W = 4;
  localparam int C_W = 4;
  localparam int O_W = 8;
  localparam int L_W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [D_W-1:0] d_conf;
  logic [C_W-1:0] h_conf;
  logic [L_W-1:0] l_conf;
  logic           en_conf, new_conf;
  logic           in_valid, in_ready;
  logic [D_W-1:0] in_data;
  logic           flush;
  logic           out_valid, out_ready;
  logic [O_W-1:0] out_data;
  logic           out_last, flush_done, err;

  always #5 clk = ~clk;

  huffman_enc #(.D_W(D_W), .C_W(C_W), .O_W(O_W)) dut (
    .clk(clk), .rst(rst), .d_conf(d_conf), .h_conf(h_conf), .l_conf(l_conf),
    .en_conf(en_conf), .new_conf(new_conf), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .flush_done(flush_done), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending stream as a queue of bits, table as plain arrays.
  bit mq[$];
  bit m_flush_state;
  bit m_err;
  int m_code [16];
  int m_len  [16];
  bit m_valid[16];

  logic       s_ir, s_ov, s_ol, s_fd, s_err;
  logic [7:0] s_od;
  logic       e_ir, e_ov, e_ol, e_fd;
  logic [7:0] e_od;

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       fl;
    logic       rdy;
    logic       e_ir;
    logic       e_ov;
    logic       e_ol;
    logic       e_fd;
    logic [7:0] e_od;
  } vec_t;
  vec_t vecs[8];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_err = 1'b0;
    m_flush_state = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic set_idle();
    rst = 0; en_conf = 0; new_conf = 0; in_valid = 0; flush = 0; out_ready = 1;
    d_conf = '0; h_conf = '0; l_conf = '0; in_data = '0;
  endtask

  // One clock: sample at negedge, compare to the model, advance the model.
  task automatic apply_stimulus();
    int n;
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_ol = out_last; s_fd = flush_done;
    s_err = err; s_od = out_data;
    n = mq.size();
    e_ir = 0; e_ov = 0; e_ol = 0; e_fd = 0;
    if (!m_flush_state) begin
      e_ir = (n < O_W) && !en_conf && !new_conf;
      e_ov = (n >= O_W);
    end else if (n >= O_W) begin
      e_ov = 1;
    end else if (n > 0) begin
      e_ov = 1; e_ol = 1; e_fd = out_ready;
    end else begin
      e_fd = 1;
    end
    for (int i = 0; i < O_W; i++) e_od[O_W-1-i] = (i < n) ? mq[i] : 1'b0;
    check_output("in_ready", s_ir, e_ir);
    check_output("out_valid", s_ov, e_ov);
    check_output("out_last", s_ol, e_ol);
    check_output("flush_done", s_fd, e_fd);
    check_output("err", s_err, m_err);
    if (e_ov) check_output("out_data", s_od, e_od);

    if (rst || new_conf) begin
      model_clear();
    end else begin
      if (in_valid && e_ir) begin
        if (m_valid[in_data]) begin
          for (int b = m_len[in_data] - 1; b >= 0; b--) mq.push_back(m_code[in_data][b]);
        end else begin
          m_err = 1'b1;
        end
      end
      if (e_ov && out_ready) begin
        if (e_ol) mq.delete();
        else repeat (O_W) void'(mq.pop_front());
      end
      if (en_conf) begin
        m_code[d_conf]  = int'(h_conf);
        m_len[d_conf]   = int'(l_conf);
        m_valid[d_conf] = (l_conf != 0);
      end
      if (!m_flush_state) begin
        if (flush) m_flush_state = 1'b1;
      end else if (n == 0 || (e_ol && out_ready)) begin
        m_flush_state = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic conf_entry(input int sym, input int code, input int len);
    en_conf = 1; d_conf = sym[3:0]; h_conf = code[3:0]; l_conf = len[2:0];
    apply_stimulus();
    en_conf = 0;
  endtask

  task automatic load_table();
    conf_entry(0, 4'b0001, 1);
    conf_entry(1, 4'b0001, 2);
    conf_entry(2, 4'b0001, 3);
    conf_entry(3, 4'b0001, 4);
  endtask

  task automatic send(input int sym);
    in_valid = 1; in_data = sym[3:0];
    apply_stimulus();
    in_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // iv, d, fl, rdy, e_ir, e_ov, e_ol, e_fd, e_od
    vecs[0] = '{1, 0, 0, 1, 1, 0, 0, 0, 8'h00};
    vecs[1] = '{1, 1, 0, 1, 1, 0, 0, 0, 8'h00};
    vecs[2] = '{1, 2, 0, 1, 1, 0, 0, 0, 8'h00};
    vecs[3] = '{1, 3, 0, 1, 1, 0, 0, 0, 8'h00};
    vecs[4] = '{0, 0, 0, 1, 0, 1, 0, 0, 8'hA4};
    vecs[5] = '{0, 0, 1, 1, 1, 0, 0, 0, 8'h00};
    vecs[6] = '{0, 0, 0, 1, 0, 1, 1, 1, 8'h40};
    vecs[7] = '{0, 0, 0, 1, 1, 0, 0, 0, 8'h00};

    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    apply_stimulus();
    rst = 0;
    apply_stimulus();
    check_output("reset_in_ready", s_ir, 1);
    check_output("reset_out_valid", s_ov, 0);
    check_output("reset_err", s_err, 0);

    load_table();
    apply_stimulus();
    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; flush = vecs[i].fl; out_ready = vecs[i].rdy;
      apply_stimulus();
      check_output($sformatf("vec%0d_in_ready", i), s_ir, vecs[i].e_ir);
      check_output($sformatf("vec%0d_out_valid", i), s_ov, vecs[i].e_ov);
      check_output($sformatf("vec%0d_out_last", i), s_ol, vecs[i].e_ol);
      check_output($sformatf("vec%0d_flush_done", i), s_fd, vecs[i].e_fd);
      if (vecs[i].e_ov) check_output($sformatf("vec%0d_out_data", i), s_od, vecs[i].e_od);
    end
    set_idle();

    // Backpressure: word must hold for 10 cycles, then transfer exactly once.
    for (int s = 0; s < 4; s++) send(s);
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check_output("hold_data", s_od, 8'hA4);
      check_output("hold_valid", s_ov, 1);
      check_output("hold_in_ready", s_ir, 0);
    end
    out_ready = 1;
    apply_stimulus();
    check_output("release_valid", s_ov, 1);
    apply_stimulus();
    check_output("single_transfer", s_ov, 0);
    flush = 1; apply_stimulus(); flush = 0;
    apply_stimulus();
    check_output("partial_data", s_od, 8'h40);
    check_output("partial_done", s_fd, 1);

    // Flush with nothing pending.
    flush = 1; apply_stimulus(); flush = 0;
    check_output("empty_flush_nov0", s_ov, 0);
    apply_stimulus();
    check_output("empty_flush_done", s_fd, 1);
    check_output("empty_flush_nov1", s_ov, 0);
    apply_stimulus();
    check_output("empty_flush_back", s_fd, 0);

    // Unconfigured symbol, then new_conf invalidates everything.
    send(5);
    check_output("err_set", s_err, 0);
    apply_stimulus();
    check_output("err_sticky", s_err, 1);
    check_output("err_no_bits", s_ov, 0);
    new_conf = 1; apply_stimulus(); new_conf = 0;
    apply_stimulus();
    check_output("err_cleared", s_err, 0);
    send(0);
    apply_stimulus();
    check_output("table_invalid", s_err, 1);

    // Reset while a partial word waits in FLUSH.
    new_conf = 1; apply_stimulus(); new_conf = 0;
    load_table();
    send(2);
    flush = 1; apply_stimulus(); flush = 0;
    out_ready = 0;
    apply_stimulus();
    check_output("flush_pending", s_ol, 1);
    rst = 1; apply_stimulus(); rst = 0; out_ready = 1;
    apply_stimulus();
    check_output("rst_out_valid", s_ov, 0);
    check_output("rst_in_ready", s_ir, 1);
    send(0);
    apply_stimulus();
    check_output("rst_table_invalid", s_err, 1);
    flush = 1; apply_stimulus(); flush = 0;
    apply_stimulus();
    check_output("rst_discarded", s_fd, 1);

    // Random traffic against the model.
    load_table();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      new_conf  = ($urandom_range(0, 249) == 0);
      en_conf   = ($urandom_range(0, 14) == 0);
      d_conf    = 4'($urandom_range(0, 15));
      h_conf    = 4'($urandom_range(0, 15));
      l_conf    = 3'($urandom_range(0, 4));
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 4'($urandom_range(0, 5));
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      apply_stimulus();
    end
    set_idle();
    apply_stimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
